// File: rtl/alu_ctrl_pipe_pkg.sv
// Shared encodings for the registered ALU control decoder: aluop/funct codes,
// ALU control codes and the sequencer state type.
package alu_ctrl_pkg;

  localparam int unsigned OPF_W_DEF  = 6;
  localparam int unsigned CTRL_W_DEF = 4;
  localparam int unsigned ALUOP_W    = 2;
  localparam int unsigned MD_LAT_DEF = 32;

  localparam logic [ALUOP_W-1:0] ALUOP_LDST  = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_BR    = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_ORI   = 2'b11;

  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_XOR  = 6'b100110;
  localparam logic [5:0] FUNCT_SLTU = 6'b101011;
  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_MULT = 6'b011000;
  localparam logic [5:0] FUNCT_DIV  = 6'b011010;

  localparam logic [3:0] ALUCTRL_AND  = 4'h0;
  localparam logic [3:0] ALUCTRL_OR   = 4'h1;
  localparam logic [3:0] ALUCTRL_ADD  = 4'h2;
  localparam logic [3:0] ALUCTRL_SLL  = 4'h3;
  localparam logic [3:0] ALUCTRL_SRL  = 4'h4;
  localparam logic [3:0] ALUCTRL_SUB  = 4'h6;
  localparam logic [3:0] ALUCTRL_SLT  = 4'h7;
  localparam logic [3:0] ALUCTRL_SLTU = 4'h8;
  localparam logic [3:0] ALUCTRL_MULT = 4'h9;
  localparam logic [3:0] ALUCTRL_DIV  = 4'hA;
  localparam logic [3:0] ALUCTRL_NOR  = 4'hC;
  localparam logic [3:0] ALUCTRL_XOR  = 4'hD;
  localparam logic [3:0] ALUCTRL_ILL  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_MD   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_ctrl_pipe_if.sv
// Decode-to-execute handshake bundle: op intake, control-code output and MD sequencing.
interface alu_ctrl_pipe_if
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned OPF_W  = OPF_W_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF
);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [ALUOP_W-1:0] aluop;
  logic [OPF_W-1:0]   opfield;
  logic               out_valid;
  logic               out_ready;
  logic [CTRL_W-1:0]  aluctrl;
  logic               illegal;
  logic               md_start;
  logic               md_busy;

  modport master (
    output flush, in_valid, aluop, opfield, out_ready,
    input  in_ready, out_valid, aluctrl, illegal, md_start, md_busy
  );

  modport slave (
    input  flush, in_valid, aluop, opfield, out_ready,
    output in_ready, out_valid, aluctrl, illegal, md_start, md_busy
  );
endinterface

// File: rtl/alu_ctrl_pipe_decode.sv
// Combinational {aluop, funct} -> ALU control code, illegal-funct flag and MULT/DIV marker.
module alu_funct_decode
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned OPF_W  = OPF_W_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF
) (
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [OPF_W-1:0]   opfield,
  output logic [CTRL_W-1:0]  aluctrl,
  output logic               illegal,
  output logic               is_md
);

  always_comb begin
    aluctrl = CTRL_W'(ALUCTRL_ADD);
    illegal = 1'b0;
    is_md   = 1'b0;
    case (aluop)
      ALUOP_LDST: aluctrl = CTRL_W'(ALUCTRL_ADD);
      ALUOP_BR:   aluctrl = CTRL_W'(ALUCTRL_SUB);
      ALUOP_ORI:  aluctrl = CTRL_W'(ALUCTRL_OR);
      default: begin
        // R-type: only here does the funct field matter
        case (opfield)
          OPF_W'(FUNCT_AND):  aluctrl = CTRL_W'(ALUCTRL_AND);
          OPF_W'(FUNCT_OR):   aluctrl = CTRL_W'(ALUCTRL_OR);
          OPF_W'(FUNCT_ADD):  aluctrl = CTRL_W'(ALUCTRL_ADD);
          OPF_W'(FUNCT_SUB):  aluctrl = CTRL_W'(ALUCTRL_SUB);
          OPF_W'(FUNCT_SLT):  aluctrl = CTRL_W'(ALUCTRL_SLT);
          OPF_W'(FUNCT_NOR):  aluctrl = CTRL_W'(ALUCTRL_NOR);
          OPF_W'(FUNCT_XOR):  aluctrl = CTRL_W'(ALUCTRL_XOR);
          OPF_W'(FUNCT_SLTU): aluctrl = CTRL_W'(ALUCTRL_SLTU);
          OPF_W'(FUNCT_SLL):  aluctrl = CTRL_W'(ALUCTRL_SLL);
          OPF_W'(FUNCT_SRL):  aluctrl = CTRL_W'(ALUCTRL_SRL);
          OPF_W'(FUNCT_MULT): begin
            aluctrl = CTRL_W'(ALUCTRL_MULT);
            is_md   = 1'b1;
          end
          OPF_W'(FUNCT_DIV): begin
            aluctrl = CTRL_W'(ALUCTRL_DIV);
            is_md   = 1'b1;
          end
          default: begin
            aluctrl = CTRL_W'(ALUCTRL_ILL);
            illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Registered ALU control stage between decode and execute; sequences multi-cycle
// MULT/DIV with a start pulse and an intake stall of MD_LAT cycles.
module alu_ctrl_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned OPF_W  = OPF_W_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned MD_LAT = MD_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_ctrl_pipe_if.slave       bus
);

  localparam int unsigned CNT_W = $clog2(MD_LAT + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [CTRL_W-1:0]  aluctrl_q, aluctrl_d;
  logic               illegal_q, illegal_d;
  logic               md_start_q, md_start_d;
  logic               md_busy_q, md_busy_d;

  logic [CTRL_W-1:0]  dec_ctrl;
  logic               dec_ill;
  logic               dec_md;
  logic               in_ready_c;
  logic               accept_c;

  alu_funct_decode #(
    .OPF_W  (OPF_W),
    .CTRL_W (CTRL_W)
  ) u_decode (
    .aluop   (bus.aluop),
    .opfield (bus.opfield),
    .aluctrl (dec_ctrl),
    .illegal (dec_ill),
    .is_md   (dec_md)
  );

  assign in_ready_c = !bus.flush &&
                      ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && bus.out_ready));
  assign accept_c   = bus.in_valid && in_ready_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      aluctrl_q   <= '0;
      illegal_q   <= 1'b0;
      md_start_q  <= 1'b0;
      md_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      aluctrl_q   <= aluctrl_d;
      illegal_q   <= illegal_d;
      md_start_q  <= md_start_d;
      md_busy_q   <= md_busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    aluctrl_d   = aluctrl_q;
    illegal_d   = illegal_q;
    md_start_d  = 1'b0;
    md_busy_d   = md_busy_q;
    if (bus.flush) begin
      // aluctrl/illegal deliberately retain their last value across a flush
      state_d     = ST_IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      md_busy_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (accept_c) begin
            aluctrl_d = dec_ctrl;
            illegal_d = dec_ill;
            if (dec_md) begin
              state_d     = ST_MD;
              cnt_d       = CNT_W'(MD_LAT - 1);
              md_start_d  = 1'b1;
              md_busy_d   = 1'b1;
              out_valid_d = 1'b0;
            end else begin
              state_d     = ST_HOLD;
              out_valid_d = 1'b1;
            end
          end else if ((state_q == ST_HOLD) && bus.out_ready) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
          end
        end
        ST_MD: begin
          if (cnt_q == '0) begin
            state_d     = ST_HOLD;
            out_valid_d = 1'b1;
            md_busy_d   = 1'b0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.aluctrl   = aluctrl_q;
  assign bus.illegal   = illegal_q;
  assign bus.md_start  = md_start_q;
  assign bus.md_busy   = md_busy_q;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Self-checking bench for alu_ctrl_pipe: vector table plus scoreboard on the output handshake.
module tb_alu_ctrl_pipe;

  localparam int unsigned MD_LAT = 4;

  logic clk = 1'b0;
  logic rst_n;

  alu_ctrl_pipe_if #(.OPF_W(6), .CTRL_W(4)) bus ();

  alu_ctrl_pipe #(
    .OPF_W  (6),
    .CTRL_W (4),
    .MD_LAT (MD_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] aluop;
    logic [5:0] funct;
    logic [3:0] ctrl;
    logic       ill;
  } vec_t;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       ill;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t cur_exp;
  exp_t popped;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                       input logic [3:0] c, input logic il);
    bus.in_valid = v;
    bus.aluop    = op;
    bus.opfield  = f;
    cur_exp      = {c, il};
  endtask

  // Scoreboard: push on accepted op, pop on output transfer; flush/reset drop pending ops
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got aluctrl %0h with nothing expected at %0t",
                   bus.aluctrl, $time);
        end else begin
          popped = sb.pop_front();
          chk("sb_aluctrl", 32'(bus.aluctrl), 32'(popped.ctrl));
          chk("sb_illegal", 32'(bus.illegal), 32'(popped.ill));
        end
      end
      if (bus.flush) sb.delete();
      else if (bus.in_valid && bus.in_ready) sb.push_back(cur_exp);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vt[12];
    vt[0]  = '{2'b10, 6'b100100, 4'b0000, 1'b0};
    vt[1]  = '{2'b10, 6'b100101, 4'b0001, 1'b0};
    vt[2]  = '{2'b10, 6'b101010, 4'b0111, 1'b0};
    vt[3]  = '{2'b10, 6'b100111, 4'b1100, 1'b0};
    vt[4]  = '{2'b10, 6'b100110, 4'b1101, 1'b0};
    vt[5]  = '{2'b10, 6'b101011, 4'b1000, 1'b0};
    vt[6]  = '{2'b10, 6'b000000, 4'b0011, 1'b0};
    vt[7]  = '{2'b10, 6'b000010, 4'b0100, 1'b0};
    vt[8]  = '{2'b10, 6'b111111, 4'b1111, 1'b1};
    vt[9]  = '{2'b01, 6'b100000, 4'b0110, 1'b0};
    vt[10] = '{2'b00, 6'b011000, 4'b0010, 1'b0};
    vt[11] = '{2'b11, 6'b111111, 4'b0001, 1'b0};

    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 2'b00, 6'b000000, 4'h0, 1'b0);

    // Reset state
    repeat (2) smp();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_aluctrl",   32'(bus.aluctrl),   32'd0);
    chk("rst_illegal",   32'(bus.illegal),   32'd0);
    chk("rst_md_start",  32'(bus.md_start),  32'd0);
    chk("rst_md_busy",   32'(bus.md_busy),   32'd0);
    nxt();
    rst_n = 1'b1;
    smp();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Single ADD, one-cycle latency
    nxt();
    drive(1'b1, 2'b10, 6'b100000, 4'b0010, 1'b0);
    smp();
    chk("add_in_ready", 32'(bus.in_ready), 32'd1);
    chk("add_ov_pre",   32'(bus.out_valid), 32'd0);
    nxt();
    drive(1'b0, 2'b00, 6'b000000, 4'h0, 1'b0);
    smp();
    chk("add_ov",      32'(bus.out_valid), 32'd1);
    chk("add_aluctrl", 32'(bus.aluctrl),   32'b0010);
    nxt();
    smp();
    chk("add_ov_drop", 32'(bus.out_valid), 32'd0);

    // Streamed table at full throughput
    for (int i = 0; i < 12; i++) begin
      nxt();
      drive(1'b1, vt[i].aluop, vt[i].funct, vt[i].ctrl, vt[i].ill);
      smp();
      chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
      if (i > 0) chk("stream_ov", 32'(bus.out_valid), 32'd1);
    end
    nxt();
    drive(1'b0, 2'b00, 6'b000000, 4'h0, 1'b0);
    smp();
    chk("stream_ov_last", 32'(bus.out_valid), 32'd1);
    nxt();
    smp();
    chk("stream_ov_drop", 32'(bus.out_valid), 32'd0);

    // Backpressure: SUB held for 3 cycles, AND waits for out_ready
    nxt();
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b10, 6'b100010, 4'b0110, 1'b0);
    smp();
    chk("bp_in_ready_idle", 32'(bus.in_ready), 32'd1);
    nxt();
    drive(1'b1, 2'b10, 6'b100100, 4'b0000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("bp_ov_hold",      32'(bus.out_valid), 32'd1);
      chk("bp_aluctrl_hold", 32'(bus.aluctrl),   32'b0110);
      chk("bp_in_ready",     32'(bus.in_ready),  32'd0);
      nxt();
    end
    bus.out_ready = 1'b1;
    smp();
    chk("bp_in_ready_release", 32'(bus.in_ready), 32'd1);
    nxt();
    drive(1'b0, 2'b00, 6'b000000, 4'h0, 1'b0);
    smp();
    chk("bp_next_ov",      32'(bus.out_valid), 32'd1);
    chk("bp_next_aluctrl", 32'(bus.aluctrl),   32'b0000);
    nxt();
    smp();
    chk("bp_ov_drop", 32'(bus.out_valid), 32'd0);

    // MULT: start pulse, busy for MD_LAT cycles, result at accept+MD_LAT+1
    nxt();
    drive(1'b1, 2'b10, 6'b011000, 4'b1001, 1'b0);
    smp();
    chk("mult_in_ready", 32'(bus.in_ready), 32'd1);
    nxt();
    drive(1'b0, 2'b00, 6'b000000, 4'h0, 1'b0);
    for (int k = 1; k <= int'(MD_LAT); k++) begin
      smp();
      chk("mult_md_busy",  32'(bus.md_busy),   32'd1);
      chk("mult_md_start", 32'(bus.md_start),  (k == 1) ? 32'd1 : 32'd0);
      chk("mult_ov_low",   32'(bus.out_valid), 32'd0);
      chk("mult_in_ready", 32'(bus.in_ready),  32'd0);
      nxt();
    end
    smp();
    chk("mult_ov",      32'(bus.out_valid), 32'd1);
    chk("mult_aluctrl", 32'(bus.aluctrl),   32'b1001);
    chk("mult_busy_lo", 32'(bus.md_busy),   32'd0);
    nxt();
    smp();
    chk("mult_ov_drop", 32'(bus.out_valid), 32'd0);

    // Flush two cycles into DIV; offered op in the flush cycle must not be taken
    nxt();
    drive(1'b1, 2'b10, 6'b011010, 4'b1010, 1'b0);
    smp();
    nxt();
    drive(1'b0, 2'b00, 6'b000000, 4'h0, 1'b0);
    smp();
    chk("div_busy1", 32'(bus.md_busy), 32'd1);
    nxt();
    smp();
    chk("div_busy2", 32'(bus.md_busy), 32'd1);
    nxt();
    bus.flush = 1'b1;
    drive(1'b1, 2'b10, 6'b100000, 4'b0010, 1'b0);
    smp();
    chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
    nxt();
    bus.flush = 1'b0;
    drive(1'b0, 2'b00, 6'b000000, 4'h0, 1'b0);
    smp();
    chk("flush_md_busy",  32'(bus.md_busy),   32'd0);
    chk("flush_ov",       32'(bus.out_valid), 32'd0);
    chk("flush_md_start", 32'(bus.md_start),  32'd0);
    chk("flush_aluctrl",  32'(bus.aluctrl),   32'b1010);
    chk("flush_in_ready_after", 32'(bus.in_ready), 32'd1);
    for (int k = 0; k <= int'(MD_LAT); k++) begin
      nxt();
      smp();
      chk("flush_no_stale_ov", 32'(bus.out_valid), 32'd0);
    end

    // Asynchronous reset mid-MULT
    nxt();
    drive(1'b1, 2'b10, 6'b011000, 4'b1001, 1'b0);
    smp();
    nxt();
    drive(1'b0, 2'b00, 6'b000000, 4'h0, 1'b0);
    smp();
    nxt();
    smp();
    chk("arst_busy_pre", 32'(bus.md_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_md_busy",   32'(bus.md_busy),   32'd0);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_aluctrl",   32'(bus.aluctrl),   32'd0);
    chk("arst_illegal",   32'(bus.illegal),   32'd0);
    chk("arst_md_start",  32'(bus.md_start),  32'd0);
    smp();
    nxt();
    rst_n = 1'b1;
    for (int k = 0; k <= int'(MD_LAT) + 1; k++) begin
      smp();
      chk("arst_rel_md_start", 32'(bus.md_start),  32'd0);
      chk("arst_rel_ov",       32'(bus.out_valid), 32'd0);
      nxt();
    end
    smp();
    chk("arst_rel_in_ready", 32'(bus.in_ready), 32'd1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
